// File: rtl/synth_ctrl_pkg.sv
// Shared constants and helpers for the synthesiser control register file.
package synth_ctrl_pkg;

  // Global register word addresses
  localparam int ADDR_SHAPE1     = 0;
  localparam int ADDR_SHAPE0     = 1;
  localparam int ADDR_ATTACK     = 2;
  localparam int ADDR_DECAY      = 3;
  localparam int ADDR_SUSTAIN    = 4;
  localparam int ADDR_RLEASE     = 5;
  localparam int ADDR_GLIDE_EN   = 6;
  localparam int ADDR_GLIDE_RATE = 7;
  localparam int ADDR_ARP_EN     = 8;
  localparam int ADDR_ARP_TIME   = 9;
  localparam int ADDR_PINGPONG   = 10;
  localparam int ADDR_CTRL       = 12;
  localparam int ADDR_VERSION    = 13;
  localparam int ADDR_COMMIT     = 14;
  localparam int ADDR_STATUS     = 15;

  // Per-voice block placement
  localparam int VOICE_BASE   = 64;
  localparam int VOICE_STRIDE = 4;

  // Stored field widths
  localparam int W_SHAPE = 2;
  localparam int W_ENV   = 16;
  localparam int W_FLAG  = 1;
  localparam int W_GLIDE = 25;
  localparam int W_ARP   = 16;
  localparam int W_KEY   = 1;
  localparam int W_FREQ  = 7;
  localparam int W_AMP   = 16;

  // Offset of a field inside one voice block
  typedef enum logic [1:0] {
    FLD_KEY  = 2'd0,
    FLD_FREQ = 2'd1,
    FLD_AMP1 = 2'd2,
    FLD_AMP0 = 2'd3
  } voice_field_e;

  // Replace the enabled bytes of old_val with the matching bytes of new_val
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/synth_ctrl_regs_shadow.sv
// One shadow/live register pair: byte-enabled writes land in the shadow,
// a transfer strobe copies the (pre-write) shadow into the live register.
module ctrl_shadow_reg
  import synth_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic          xfer,
  output logic [W-1:0]  shadow_o,
  output logic [W-1:0]  live_o
);

  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] live_q, live_d;

  // Next-state: byte-merged write into shadow, old shadow into live on transfer
  always_comb begin
    shadow_d = shadow_q;
    live_d   = live_q;
    if (wr_en) begin
      shadow_d = W'(be_merge(32'(shadow_q), wdata, be));
    end else begin
      shadow_d = shadow_q;
    end
    if (xfer) begin
      live_d = shadow_q;
    end else begin
      live_d = live_q;
    end
  end

  // Shadow and live state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      live_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      live_q   <= live_d;
    end
  end

  assign shadow_o = shadow_q;
  assign live_o   = live_q;

endmodule

// File: rtl/synth_ctrl_regs.sv
// Avalon-MM control register file for the synthesiser core: shadowed global
// and per-voice parameters with atomic commit on sample tick or immediate mode.
module synth_ctrl_regs
  import synth_ctrl_pkg::*;
#(
  parameter int          NUM_VOICES = 8,
  parameter int          ADDR_W     = 7,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic                             SAMPLE_TICK,
  input  logic [ADDR_W-1:0]                AVL_ADDR,
  input  logic [3:0]                       AVL_BYTE_EN,
  input  logic                             AVL_READ,
  input  logic                             AVL_WRITE,
  input  logic                             AVL_CS,
  input  logic [31:0]                      AVL_WRITEDATA,
  output logic [31:0]                      AVL_READDATA,
  output logic                             AVL_READDATAVALID,
  output logic [1:0]                       SHAPE1,
  output logic [1:0]                       SHAPE0,
  output logic [15:0]                      ATTACK,
  output logic [15:0]                      DECAY,
  output logic [15:0]                      SUSTAIN,
  output logic [15:0]                      RLEASE,
  output logic [15:0]                      ARP_TIME,
  output logic [24:0]                      GLIDE_RATE,
  output logic                             GLIDE_EN,
  output logic                             ARP_EN,
  output logic                             PINGPONGEN,
  output logic [NUM_VOICES-1:0]            KEY,
  output logic [NUM_VOICES-1:0][6:0]       FREQ,
  output logic [NUM_VOICES-1:0][15:0]      AMP1,
  output logic [NUM_VOICES-1:0][15:0]      AMP0,
  output logic                             COMMIT_PENDING
);

  logic wr_s, rd_s;
  logic [10:0] gwr_s;
  logic ctrl_wr_s, commit_wr_s, status_wr_s, commit_req_s;
  logic tick_xfer_s, xfer_s;

  logic imm_q, imm_d, pending_q, pending_d, ovf_q, ovf_d;
  logic [31:0] rdata_s, rdata_q, rdata_d, voice_rdata_s;
  logic valid_q, valid_d;

  logic [1:0]  sh_shape1_s, sh_shape0_s;
  logic [15:0] sh_attack_s, sh_decay_s, sh_sustain_s, sh_rlease_s, sh_arp_time_s;
  logic [24:0] sh_glide_rate_s;
  logic        sh_glide_en_s, sh_arp_en_s, sh_pingpong_s;

  logic [NUM_VOICES-1:0]       key_sh_s;
  logic [NUM_VOICES-1:0][6:0]  freq_sh_s;
  logic [NUM_VOICES-1:0][15:0] amp1_sh_s, amp0_sh_s;
  logic [NUM_VOICES-1:0]       vsel_s;
  logic [NUM_VOICES-1:0][31:0] vrd_s;

  logic [ADDR_W-1:0] voff_s;
  logic              voice_hit_s;
  voice_field_e      voice_fld_s;

  assign wr_s = AVL_WRITE & AVL_CS;
  assign rd_s = AVL_READ & AVL_CS;

  // Global field write strobes, one per address 0..10
  for (genvar g = 0; g < 11; g++) begin : g_gwr
    assign gwr_s[g] = wr_s && (AVL_ADDR == ADDR_W'(g));
  end

  assign ctrl_wr_s   = wr_s && (AVL_ADDR == ADDR_W'(ADDR_CTRL));
  assign commit_wr_s = wr_s && (AVL_ADDR == ADDR_W'(ADDR_COMMIT));
  assign status_wr_s = wr_s && (AVL_ADDR == ADDR_W'(ADDR_STATUS));
  assign commit_req_s = commit_wr_s & AVL_BYTE_EN[0] & AVL_WRITEDATA[0];

  // A pending commit is consumed by the tick; immediate mode copies every cycle
  assign tick_xfer_s = SAMPLE_TICK & pending_q;
  assign xfer_s      = imm_q | tick_xfer_s;

  // Voice window decode: offset from VOICE_BASE, voice index, field
  assign voff_s      = AVL_ADDR - ADDR_W'(VOICE_BASE);
  assign voice_hit_s = (AVL_ADDR >= ADDR_W'(VOICE_BASE)) &&
                       (int'(voff_s[ADDR_W-1:2]) < NUM_VOICES);
  assign voice_fld_s = voice_field_e'(voff_s[1:0]);

  ctrl_shadow_reg #(.W(W_SHAPE)) u_shape1 (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_SHAPE1]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_shape1_s), .live_o(SHAPE1));
  ctrl_shadow_reg #(.W(W_SHAPE)) u_shape0 (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_SHAPE0]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_shape0_s), .live_o(SHAPE0));
  ctrl_shadow_reg #(.W(W_ENV)) u_attack (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_ATTACK]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_attack_s), .live_o(ATTACK));
  ctrl_shadow_reg #(.W(W_ENV)) u_decay (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_DECAY]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_decay_s), .live_o(DECAY));
  ctrl_shadow_reg #(.W(W_ENV)) u_sustain (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_SUSTAIN]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_sustain_s), .live_o(SUSTAIN));
  ctrl_shadow_reg #(.W(W_ENV)) u_rlease (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_RLEASE]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_rlease_s), .live_o(RLEASE));
  ctrl_shadow_reg #(.W(W_FLAG)) u_glide_en (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_GLIDE_EN]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_glide_en_s), .live_o(GLIDE_EN));
  ctrl_shadow_reg #(.W(W_GLIDE)) u_glide_rate (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_GLIDE_RATE]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_glide_rate_s), .live_o(GLIDE_RATE));
  ctrl_shadow_reg #(.W(W_FLAG)) u_arp_en (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_ARP_EN]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_arp_en_s), .live_o(ARP_EN));
  ctrl_shadow_reg #(.W(W_ARP)) u_arp_time (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_ARP_TIME]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_arp_time_s), .live_o(ARP_TIME));
  ctrl_shadow_reg #(.W(W_FLAG)) u_pingpong (.clk(CLK), .rst_n(RESET_N), .wr_en(gwr_s[ADDR_PINGPONG]),
    .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(sh_pingpong_s), .live_o(PINGPONGEN));

  // Per-voice registers and their read words
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign vsel_s[v] = voice_hit_s && (int'(voff_s[ADDR_W-1:2]) == v);

    ctrl_shadow_reg #(.W(W_KEY)) u_key (.clk(CLK), .rst_n(RESET_N),
      .wr_en(wr_s && vsel_s[v] && (voice_fld_s == FLD_KEY)),
      .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(key_sh_s[v]), .live_o(KEY[v]));
    ctrl_shadow_reg #(.W(W_FREQ)) u_freq (.clk(CLK), .rst_n(RESET_N),
      .wr_en(wr_s && vsel_s[v] && (voice_fld_s == FLD_FREQ)),
      .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(freq_sh_s[v]), .live_o(FREQ[v]));
    ctrl_shadow_reg #(.W(W_AMP)) u_amp1 (.clk(CLK), .rst_n(RESET_N),
      .wr_en(wr_s && vsel_s[v] && (voice_fld_s == FLD_AMP1)),
      .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(amp1_sh_s[v]), .live_o(AMP1[v]));
    ctrl_shadow_reg #(.W(W_AMP)) u_amp0 (.clk(CLK), .rst_n(RESET_N),
      .wr_en(wr_s && vsel_s[v] && (voice_fld_s == FLD_AMP0)),
      .wdata(AVL_WRITEDATA), .be(AVL_BYTE_EN), .xfer(xfer_s), .shadow_o(amp0_sh_s[v]), .live_o(AMP0[v]));

    assign vrd_s[v] = !vsel_s[v]                ? 32'd0 :
                      (voice_fld_s == FLD_KEY)  ? {31'd0, key_sh_s[v]} :
                      (voice_fld_s == FLD_FREQ) ? {25'd0, freq_sh_s[v]} :
                      (voice_fld_s == FLD_AMP1) ? {16'd0, amp1_sh_s[v]} :
                                                  {16'd0, amp0_sh_s[v]};
  end

  // Collapse the one-hot voice read words into a single word
  always_comb begin
    voice_rdata_s = 32'd0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_rdata_s = voice_rdata_s | vrd_s[v];
    end
  end

  // Read mux: zero-extended shadow values, constants, status; unmapped reads 0
  always_comb begin
    rdata_s = 32'd0;
    case (AVL_ADDR)
      ADDR_W'(ADDR_SHAPE1):     rdata_s = {30'd0, sh_shape1_s};
      ADDR_W'(ADDR_SHAPE0):     rdata_s = {30'd0, sh_shape0_s};
      ADDR_W'(ADDR_ATTACK):     rdata_s = {16'd0, sh_attack_s};
      ADDR_W'(ADDR_DECAY):      rdata_s = {16'd0, sh_decay_s};
      ADDR_W'(ADDR_SUSTAIN):    rdata_s = {16'd0, sh_sustain_s};
      ADDR_W'(ADDR_RLEASE):     rdata_s = {16'd0, sh_rlease_s};
      ADDR_W'(ADDR_GLIDE_EN):   rdata_s = {31'd0, sh_glide_en_s};
      ADDR_W'(ADDR_GLIDE_RATE): rdata_s = {7'd0, sh_glide_rate_s};
      ADDR_W'(ADDR_ARP_EN):     rdata_s = {31'd0, sh_arp_en_s};
      ADDR_W'(ADDR_ARP_TIME):   rdata_s = {16'd0, sh_arp_time_s};
      ADDR_W'(ADDR_PINGPONG):   rdata_s = {31'd0, sh_pingpong_s};
      ADDR_W'(ADDR_CTRL):       rdata_s = {31'd0, imm_q};
      ADDR_W'(ADDR_VERSION):    rdata_s = VERSION;
      ADDR_W'(ADDR_STATUS):     rdata_s = {30'd0, ovf_q, pending_q};
      default:                  rdata_s = voice_rdata_s;
    endcase
  end

  // Control/status next state: IMMEDIATE bit, commit pending and sticky overflow
  always_comb begin
    imm_d     = imm_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    rdata_d   = rdata_q;
    valid_d   = rd_s;
    if (ctrl_wr_s && AVL_BYTE_EN[0]) begin
      imm_d = AVL_WRITEDATA[0];
    end else begin
      imm_d = imm_q;
    end
    if (tick_xfer_s) begin
      // A commit landing on the transfer tick re-arms for the next tick
      pending_d = commit_req_s;
      ovf_d     = ovf_q;
    end else if (commit_req_s) begin
      pending_d = 1'b1;
      ovf_d     = ovf_q | pending_q;
    end else begin
      pending_d = pending_q;
      ovf_d     = ovf_q;
    end
    if (status_wr_s && AVL_BYTE_EN[0] && AVL_WRITEDATA[1]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_d;
    end
    if (rd_s) begin
      rdata_d = rdata_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control/status and read-return registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      imm_q     <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      imm_q     <= imm_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
    end
  end

  assign AVL_READDATA      = rdata_q;
  assign AVL_READDATAVALID = valid_q;
  assign COMMIT_PENDING    = pending_q;

endmodule

// File: tb/tb_synth_ctrl_regs.sv
// Directed self-checking bench for synth_ctrl_regs (NUM_VOICES=8, ADDR_W=7).
module tb_synth_ctrl_regs;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        SAMPLE_TICK = 1'b0;
  logic [6:0]  AVL_ADDR = 7'd0;
  logic [3:0]  AVL_BYTE_EN = 4'd0;
  logic        AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
  logic [31:0] AVL_WRITEDATA = 32'd0;
  logic [31:0] AVL_READDATA;
  logic        AVL_READDATAVALID;
  logic [1:0]  SHAPE1, SHAPE0;
  logic [15:0] ATTACK, DECAY, SUSTAIN, RLEASE, ARP_TIME;
  logic [24:0] GLIDE_RATE;
  logic        GLIDE_EN, ARP_EN, PINGPONGEN;
  logic [7:0]  KEY;
  logic [7:0][6:0]  FREQ;
  logic [7:0][15:0] AMP1, AMP0;
  logic        COMMIT_PENDING;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [32:0] r;

  synth_ctrl_regs #(.NUM_VOICES(8), .ADDR_W(7), .VERSION(32'h0002_0000)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SAMPLE_TICK(SAMPLE_TICK),
    .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_READDATAVALID(AVL_READDATAVALID),
    .SHAPE1(SHAPE1), .SHAPE0(SHAPE0), .ATTACK(ATTACK), .DECAY(DECAY),
    .SUSTAIN(SUSTAIN), .RLEASE(RLEASE), .ARP_TIME(ARP_TIME),
    .GLIDE_RATE(GLIDE_RATE), .GLIDE_EN(GLIDE_EN), .ARP_EN(ARP_EN),
    .PINGPONGEN(PINGPONGEN), .KEY(KEY), .FREQ(FREQ), .AMP1(AMP1),
    .AMP0(AMP0), .COMMIT_PENDING(COMMIT_PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One write cycle, optionally with SAMPLE_TICK in the same cycle
  task automatic wr_tick(input logic [6:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic tk);
    @(negedge CLK);
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    AVL_WRITE = 1'b1; AVL_CS = 1'b1; SAMPLE_TICK = tk;
    @(negedge CLK);
    AVL_WRITE = 1'b0; AVL_CS = 1'b0; SAMPLE_TICK = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    wr_tick(a, d, 4'hF, 1'b0);
  endtask

  // Single read; returns {valid, data} one cycle after the request is sampled
  task automatic rd(input logic [6:0] a, output logic [32:0] res);
    @(negedge CLK);
    AVL_ADDR = a; AVL_READ = 1'b1; AVL_CS = 1'b1;
    @(negedge CLK);
    AVL_READ = 1'b0; AVL_CS = 1'b0;
    res = {AVL_READDATAVALID, AVL_READDATA};
  endtask

  task automatic tick();
    @(negedge CLK);
    SAMPLE_TICK = 1'b1;
    @(negedge CLK);
    SAMPLE_TICK = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge CLK);
    chk("rst_outs", 64'(|{SHAPE1, SHAPE0, ATTACK, DECAY, SUSTAIN, RLEASE, ARP_TIME,
        GLIDE_RATE, GLIDE_EN, ARP_EN, PINGPONGEN, KEY, FREQ, AMP1, AMP0,
        COMMIT_PENDING, AVL_READDATAVALID, AVL_READDATA}), 64'd0);
    RESET_N = 1'b1;

    // Full address sweep after reset
    for (int a = 0; a < 128; a++) begin
      rd(7'(a), r);
      chk("rd_reset_sweep", 64'(r), (a == 13) ? 64'h1_0002_0000 : 64'h1_0000_0000);
    end
    @(negedge CLK);
    chk("valid_drops", 64'(AVL_READDATAVALID), 64'd0);

    // FREQ v3 single byte lane, then commit
    wr_tick(7'd77, 32'hFFFF_FF45, 4'b0001, 1'b0);
    rd(7'd77, r);
    chk("freq3_shadow", 64'(r), 64'h1_0000_0045);
    chk("freq3_live_before", 64'(FREQ[3]), 64'd0);
    wr(7'd14, 32'd1);
    chk("pending_set", 64'(COMMIT_PENDING), 64'd1);
    chk("freq3_live_no_tick", 64'(FREQ[3]), 64'd0);
    tick();
    chk("freq3_live_after", 64'(FREQ[3]), 64'h45);
    chk("pending_clr", 64'(COMMIT_PENDING), 64'd0);

    // KEY v0..v7 land together
    for (int v = 0; v < 8; v++) wr(7'(64 + 4 * v), 32'd1);
    wr(7'd14, 32'd1);
    chk("key_before_tick", 64'(KEY), 64'h00);
    tick();
    chk("key_after_tick", 64'(KEY), 64'hFF);
    rd(7'd15, r);
    chk("status_after_key", 64'(r), 64'h1_0000_0000);

    // Double commit sets OVF, writing bit1 clears it
    wr(7'd14, 32'd1);
    wr(7'd14, 32'd1);
    rd(7'd15, r);
    chk("status_ovf", 64'(r), 64'h1_0000_0003);
    wr(7'd15, 32'd2);
    rd(7'd15, r);
    chk("status_ovf_clr", 64'(r), 64'h1_0000_0001);
    tick();
    rd(7'd15, r);
    chk("status_idle", 64'(r), 64'h1_0000_0000);

    // Shadow write in the transfer cycle
    wr(7'd2, 32'd100);
    wr(7'd14, 32'd1);
    wr_tick(7'd2, 32'd200, 4'hF, 1'b1);
    chk("attack_live_old", 64'(ATTACK), 64'd100);
    rd(7'd2, r);
    chk("attack_shadow_new", 64'(r), 64'h1_0000_00C8);
    wr(7'd14, 32'd1);
    tick();
    chk("attack_live_new", 64'(ATTACK), 64'd200);

    // Tick with commit while pending: transfer, pending kept, OVF unchanged
    wr(7'd4, 32'd5);
    wr(7'd14, 32'd1);
    wr(7'd4, 32'd6);
    wr_tick(7'd14, 32'd1, 4'hF, 1'b1);
    chk("sustain_xfer", 64'(SUSTAIN), 64'd6);
    chk("pending_rearmed", 64'(COMMIT_PENDING), 64'd1);
    rd(7'd15, r);
    chk("status_no_ovf", 64'(r), 64'h1_0000_0001);
    tick();
    rd(7'd15, r);
    chk("status_after_rearm", 64'(r), 64'h1_0000_0000);

    // Tick with commit while idle: transfer waits for next tick
    wr(7'd3, 32'd7);
    wr_tick(7'd14, 32'd1, 4'hF, 1'b1);
    chk("decay_waits", 64'(DECAY), 64'd0);
    chk("pending_from_idle", 64'(COMMIT_PENDING), 64'd1);
    tick();
    chk("decay_lands", 64'(DECAY), 64'd7);

    // Width truncation and byte enables on the 25-bit field
    wr(7'd7, 32'hFFFF_FFFF);
    rd(7'd7, r);
    chk("glide_trunc", 64'(r), 64'h1_01FF_FFFF);
    wr_tick(7'd7, 32'h0000_0000, 4'b0100, 1'b0);
    rd(7'd7, r);
    chk("glide_be", 64'(r), 64'h1_0100_FFFF);

    // Back-to-back reads
    @(negedge CLK);
    AVL_ADDR = 7'd7; AVL_READ = 1'b1; AVL_CS = 1'b1;
    @(negedge CLK);
    chk("b2b_first", 64'({AVL_READDATAVALID, AVL_READDATA}), 64'h1_0100_FFFF);
    AVL_ADDR = 7'd13;
    @(negedge CLK);
    AVL_READ = 1'b0; AVL_CS = 1'b0;
    chk("b2b_second", 64'({AVL_READDATAVALID, AVL_READDATA}), 64'h1_0002_0000);
    @(negedge CLK);
    chk("b2b_done", 64'(AVL_READDATAVALID), 64'd0);

    // Immediate mode: live follows shadow two cycles after the write
    wr(7'd12, 32'd1);
    wr(7'd75, 32'h0000_1234);
    chk("amp0_imm_1cyc", 64'(AMP0[2]), 64'd0);
    @(negedge CLK);
    chk("amp0_imm_2cyc", 64'(AMP0[2]), 64'h1234);
    chk("glide_imm", 64'(GLIDE_RATE), 64'h100_FFFF);
    rd(7'd12, r);
    chk("ctrl_rd", 64'(r), 64'h1_0000_0001);

    // Voices beyond NUM_VOICES are unmapped
    wr(7'd100, 32'd1);
    rd(7'd100, r);
    chk("voice9_rd", 64'(r), 64'h1_0000_0000);
    rd(7'd127, r);
    chk("voice15_rd", 64'(r), 64'h1_0000_0000);
    chk("key_unchanged", 64'(KEY), 64'hFF);

    // Reset during an in-flight read
    @(negedge CLK);
    AVL_ADDR = 7'd2; AVL_READ = 1'b1; AVL_CS = 1'b1;
    @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(AVL_READDATAVALID), 64'd0);
    chk("rst_mid_data", 64'(AVL_READDATA), 64'd0);
    chk("rst_mid_attack", 64'(ATTACK), 64'd0);
    chk("rst_mid_key", 64'(KEY), 64'd0);
    @(negedge CLK);
    AVL_READ = 1'b0; AVL_CS = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    rd(7'd12, r);
    chk("ctrl_after_rst", 64'(r), 64'h1_0000_0000);
    rd(7'd2, r);
    chk("attack_sh_after_rst", 64'(r), 64'h1_0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
